// File: rtl/cache_axi_bridge_if.sv
// Bundles the icache/dcache request ports and the AXI4 master channels.
// Latency: none, signal container only.
// Backpressure: carried by the *_rdy, *ready and *valid signals it declares.
// Modports:
//   master - the bridge side. It takes cache requests and slave responses,
//            and drives the AXI requests, the cache readies and the return beats.
//   slave  - the environment side. It is the caches plus the AXI slave.
interface cache_axi_bridge_if #(
   parameter int LINE_WORDS = 4
);
   // icache read request
   logic                      i_rd_req;
   logic [2:0]                i_rd_type;
   logic [31:0]               i_rd_addr;
   logic                      i_rd_rdy;
   // dcache read request
   logic                      d_rd_req;
   logic [2:0]                d_rd_type;
   logic [31:0]               d_rd_addr;
   logic                      d_rd_rdy;
   // shared return beat
   logic                      i_ret_valid;
   logic                      d_ret_valid;
   logic                      ret_last;
   logic [31:0]               ret_data;
   // dcache write
   logic                      wr_req;
   logic [2:0]                wr_type;
   logic [31:0]               wr_addr;
   logic [3:0]                wr_wstrb;
   logic [32*LINE_WORDS-1:0]  wr_data;
   logic                      wr_rdy;
   // AXI AR
   logic [3:0]                arid;
   logic [31:0]               araddr;
   logic [7:0]                arlen;
   logic [2:0]                arsize;
   logic                      arvalid;
   logic                      arready;
   // AXI R
   logic [3:0]                rid;
   logic [31:0]               rdata;
   logic                      rlast;
   logic                      rvalid;
   logic                      rready;
   // AXI AW
   logic [31:0]               awaddr;
   logic [7:0]                awlen;
   logic [2:0]                awsize;
   logic                      awvalid;
   logic                      awready;
   // AXI W
   logic [31:0]               wdata;
   logic [3:0]                wstrb;
   logic                      wlast;
   logic                      wvalid;
   logic                      wready;
   // AXI B
   logic                      bvalid;
   logic                      bready;

   modport master (
      input  i_rd_req, i_rd_type, i_rd_addr,
      output i_rd_rdy,
      input  d_rd_req, d_rd_type, d_rd_addr,
      output d_rd_rdy,
      output i_ret_valid, d_ret_valid, ret_last, ret_data,
      input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
      output wr_rdy,
      output arid, araddr, arlen, arsize, arvalid,
      input  arready,
      input  rid, rdata, rlast, rvalid,
      output rready,
      output awaddr, awlen, awsize, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bvalid,
      output bready
   );

   modport slave (
      output i_rd_req, i_rd_type, i_rd_addr,
      input  i_rd_rdy,
      output d_rd_req, d_rd_type, d_rd_addr,
      input  d_rd_rdy,
      input  i_ret_valid, d_ret_valid, ret_last, ret_data,
      output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
      input  wr_rdy,
      input  arid, araddr, arlen, arsize, arvalid,
      output arready,
      output rid, rdata, rlast, rvalid,
      input  rready,
      input  awaddr, awlen, awsize, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bvalid,
      input  bready
   );
endinterface

// File: rtl/cache_axi_bridge.sv
// Arbitrates icache/dcache refill reads and dcache writebacks onto one AXI4 master.
// Latency: AR/AW/first W valid one cycle after capture; read return beats pass through combinationally.
// Backpressure: one outstanding read per cache and one write; *_rdy low while busy, AXI valids held until ready.
// Ports:
//   clock - the only clock.
//   reset - asynchronous, active-high.
//   bus   - the cache request/return ports and the AXI AR/R/AW/W/B channels (master modport).
module cache_axi_bridge #(
   parameter int LINE_WORDS = 4
) (
   input  logic                clock,
   input  logic                reset,
   cache_axi_bridge_if.master  bus
);

   localparam int         BW        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [2:0] TYPE_LINE = 3'b100;
   localparam logic [7:0] LINE_LEN  = 8'(LINE_WORDS - 1);

   localparam logic [0:0] AR_IDLE = 1'b0;
   localparam logic [0:0] AR_SEND = 1'b1;

   localparam logic [1:0] W_IDLE  = 2'd0;
   localparam logic [1:0] W_SEND  = 2'd1;
   localparam logic [1:0] W_RESP  = 2'd2;

   // Burst length for a request type: a full line or a single beat.
   function automatic logic [7:0] f_len(input logic [2:0] typ);
      return (typ == TYPE_LINE) ? LINE_LEN : 8'd0;
   endfunction

   // Beat size: line refills use whole words, sub-line accesses use their own width.
   function automatic logic [2:0] f_size(input logic [2:0] typ);
      return (typ == TYPE_LINE) ? 3'd2 : {1'b0, typ[1:0]};
   endfunction

   // ---------------------------------------------------------------- state
   logic [0:0]               r_ar_state;
   logic [1:0]               r_w_state;
   logic                     r_i_out;
   logic                     r_d_out;

   logic [3:0]               r_arid;
   logic [31:0]              r_araddr;
   logic [7:0]               r_arlen;
   logic [2:0]               r_arsize;

   logic [31:0]              r_awaddr;
   logic [7:0]               r_awlen;
   logic [2:0]               r_awsize;
   logic [3:0]               r_wstrb;
   logic [32*LINE_WORDS-1:0] r_wdata;
   logic                     r_aw_done;
   logic                     r_w_done;
   logic [BW-1:0]            r_beat;

   // ---------------------------------------------------------------- ready / accept
   logic w_ar_idle;
   logic w_w_idle;
   logic w_d_rd_rdy;
   logic w_i_rd_rdy;
   logic w_wr_rdy;
   logic w_d_acc;
   logic w_i_acc;
   logic w_wr_acc;

   assign w_ar_idle  = (r_ar_state == AR_IDLE);
   assign w_w_idle   = (r_w_state == W_IDLE);

   // The readies are forced low while reset is held, even though the state is already idle.
   assign w_d_rd_rdy = ~reset & w_ar_idle & ~r_d_out & w_w_idle;
   // The icache yields to a dcache request that is being taken in the same cycle.
   assign w_i_rd_rdy = ~reset & w_ar_idle & ~r_i_out & w_w_idle
                       & ~(bus.d_rd_req & w_d_rd_rdy);
   // A write waits for an outstanding dcache read so a refill never races its own writeback.
   assign w_wr_rdy   = ~reset & w_w_idle & ~r_d_out;

   assign w_d_acc    = bus.d_rd_req & w_d_rd_rdy;
   assign w_i_acc    = bus.i_rd_req & w_i_rd_rdy;
   assign w_wr_acc   = bus.wr_req & w_wr_rdy;

   // ---------------------------------------------------------------- read return
   logic w_r_end;
   logic w_i_done;
   logic w_d_done;

   assign w_r_end  = bus.rvalid & bus.rlast;
   assign w_i_done = w_r_end & (bus.rid == 4'd0);
   assign w_d_done = w_r_end & (bus.rid == 4'd1);

   // ---------------------------------------------------------------- read-address FSM
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ar_state <= AR_IDLE;
         r_arid     <= 4'd0;
         r_araddr   <= 32'd0;
         r_arlen    <= 8'd0;
         r_arsize   <= 3'd0;
      end else if (r_ar_state == AR_IDLE) begin
         if (w_d_acc) begin
            r_ar_state <= AR_SEND;
            r_arid     <= 4'd1;
            r_araddr   <= bus.d_rd_addr;
            r_arlen    <= f_len(bus.d_rd_type);
            r_arsize   <= f_size(bus.d_rd_type);
         end else if (w_i_acc) begin
            r_ar_state <= AR_SEND;
            r_arid     <= 4'd0;
            r_araddr   <= bus.i_rd_addr;
            r_arlen    <= f_len(bus.i_rd_type);
            r_arsize   <= f_size(bus.i_rd_type);
         end
      end else begin
         if (bus.arready) begin
            r_ar_state <= AR_IDLE;
         end
      end
   end

   // A cache's outstanding flag lives from capture until the last beat carrying its ID.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_i_out <= 1'b0;
         r_d_out <= 1'b0;
      end else begin
         if (w_i_acc) begin
            r_i_out <= 1'b1;
         end else if (w_i_done) begin
            r_i_out <= 1'b0;
         end
         if (w_d_acc) begin
            r_d_out <= 1'b1;
         end else if (w_d_done) begin
            r_d_out <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- write FSM
   logic w_aw_hs;
   logic w_w_hs;
   logic w_wlast;
   logic w_aw_fin;
   logic w_w_fin;

   assign w_aw_hs  = bus.awvalid & bus.awready;
   assign w_w_hs   = bus.wvalid & bus.wready;
   assign w_wlast  = (8'(r_beat) == r_awlen);
   // Either channel may finish first; each counts as done on its handshake or after it.
   assign w_aw_fin = r_aw_done | w_aw_hs;
   assign w_w_fin  = r_w_done | (w_w_hs & w_wlast);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_w_state <= W_IDLE;
         r_awaddr  <= 32'd0;
         r_awlen   <= 8'd0;
         r_awsize  <= 3'd0;
         r_wstrb   <= 4'd0;
         r_wdata   <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_beat    <= '0;
      end else begin
         case (r_w_state)
            W_IDLE: begin
               if (w_wr_acc) begin
                  r_w_state <= W_SEND;
                  r_awaddr  <= bus.wr_addr;
                  r_awlen   <= f_len(bus.wr_type);
                  r_awsize  <= f_size(bus.wr_type);
                  r_wstrb   <= (bus.wr_type == TYPE_LINE) ? 4'hF : bus.wr_wstrb;
                  r_wdata   <= bus.wr_data;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_beat    <= '0;
               end
            end
            W_SEND: begin
               if (w_aw_hs) begin
                  r_aw_done <= 1'b1;
               end
               if (w_w_hs) begin
                  if (w_wlast) begin
                     r_w_done <= 1'b1;
                  end else begin
                     r_beat <= r_beat + 1'b1;
                  end
               end
               if (w_aw_fin && w_w_fin) begin
                  r_w_state <= W_RESP;
               end
            end
            W_RESP: begin
               if (bus.bvalid) begin
                  r_w_state <= W_IDLE;
                  r_beat    <= '0;
               end
            end
            default: begin
               r_w_state <= W_IDLE;
            end
         endcase
      end
   end

   // Beat k of a line is word k of the captured data; single-beat writes use word 0.
   logic [31:0] w_beats [LINE_WORDS];

   for (genvar g = 0; g < LINE_WORDS; g++) begin : g_beat
      assign w_beats[g] = r_wdata[32*g +: 32];
   end

   // ---------------------------------------------------------------- outputs
   assign bus.d_rd_rdy    = w_d_rd_rdy;
   assign bus.i_rd_rdy    = w_i_rd_rdy;
   assign bus.wr_rdy      = w_wr_rdy;

   assign bus.arid        = r_arid;
   assign bus.araddr      = r_araddr;
   assign bus.arlen       = r_arlen;
   assign bus.arsize      = r_arsize;
   assign bus.arvalid     = (r_ar_state == AR_SEND);

   // Return beats are steered by ID with no added latency; reset suppresses them.
   assign bus.rready      = 1'b1;
   assign bus.ret_data    = reset ? 32'd0 : bus.rdata;
   assign bus.ret_last    = ~reset & bus.rlast;
   assign bus.i_ret_valid = ~reset & bus.rvalid & (bus.rid == 4'd0);
   assign bus.d_ret_valid = ~reset & bus.rvalid & (bus.rid == 4'd1);

   assign bus.awaddr      = r_awaddr;
   assign bus.awlen       = r_awlen;
   assign bus.awsize      = r_awsize;
   assign bus.awvalid     = (r_w_state == W_SEND) & ~r_aw_done;

   assign bus.wdata       = w_beats[r_beat];
   assign bus.wstrb       = r_wstrb;
   assign bus.wlast       = w_wlast;
   assign bus.wvalid      = (r_w_state == W_SEND) & ~r_w_done;

   assign bus.bready      = (r_w_state == W_RESP);

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: expected AR/AW/W/return beats are queued as
// stimulus is driven and compared by a monitor when the DUT produces them.
`timescale 1ns/1ps
module tb_cache_axi_bridge;
   localparam int LW = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   cache_axi_bridge_if #(.LINE_WORDS(LW)) bus();

   cache_axi_bridge #(.LINE_WORDS(LW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Scoreboard queues
   logic [46:0] q_ar[$];   // {arid, araddr, arlen, arsize}
   logic [42:0] q_aw[$];   // {awaddr, awlen, awsize}
   logic [36:0] q_w[$];    // {wdata, wstrb, wlast}
   logic [34:0] q_r[$];    // {i_ret_valid, d_ret_valid, ret_data, ret_last}

   logic [46:0] m_ar;
   logic [42:0] m_aw;
   logic [36:0] m_w;
   logic [34:0] m_r;

   always @(negedge clock) begin
      if (!reset) begin
         if (bus.arvalid && bus.arready) begin
            if (q_ar.size() == 0) chk("ar_unexpected", 1, 0);
            else begin
               m_ar = q_ar.pop_front();
               chk("ar_fields", {bus.arid, bus.araddr, bus.arlen, bus.arsize}, m_ar);
            end
         end
         if (bus.awvalid && bus.awready) begin
            if (q_aw.size() == 0) chk("aw_unexpected", 1, 0);
            else begin
               m_aw = q_aw.pop_front();
               chk("aw_fields", {bus.awaddr, bus.awlen, bus.awsize}, m_aw);
            end
         end
         if (bus.wvalid && bus.wready) begin
            if (q_w.size() == 0) chk("w_unexpected", 1, 0);
            else begin
               m_w = q_w.pop_front();
               chk("w_beat", {bus.wdata, bus.wstrb, bus.wlast}, m_w);
            end
         end
         if (bus.rvalid) begin
            if (q_r.size() == 0) chk("ret_unexpected", 1, 0);
            else begin
               m_r = q_r.pop_front();
               chk("ret_beat", {bus.i_ret_valid, bus.d_ret_valid, bus.ret_data, bus.ret_last}, m_r);
            end
         end else begin
            chk("ret_idle", {bus.i_ret_valid, bus.d_ret_valid}, 2'b00);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Raise a read request and hold it until the matching ready is seen; queue the expected AR.
   task automatic rd_req(input bit dc, input logic [31:0] a, input logic [2:0] t,
                         input logic [7:0] elen, input logic [2:0] esize);
      bit got = 0;
      if (dc) begin
         bus.d_rd_req = 1'b1; bus.d_rd_addr = a; bus.d_rd_type = t;
      end else begin
         bus.i_rd_req = 1'b1; bus.i_rd_addr = a; bus.i_rd_type = t;
      end
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clock);
         if (dc ? bus.d_rd_rdy : bus.i_rd_rdy) begin
            got = 1;
            q_ar.push_back({(dc ? 4'd1 : 4'd0), a, elen, esize});
         end
         tick();
      end
      if (!got) chk("rd_req_timeout", 0, 1);
      if (dc) bus.d_rd_req = 1'b0;
      else    bus.i_rd_req = 1'b0;
   endtask

   task automatic r_send(input logic [3:0] id, input logic [31:0] d, input bit last);
      bus.rvalid = 1'b1; bus.rid = id; bus.rdata = d; bus.rlast = last;
      q_r.push_back({(id == 4'd0), (id == 4'd1), d, last});
      tick();
      bus.rvalid = 1'b0; bus.rlast = 1'b0;
   endtask

   task automatic wr_req(input logic [31:0] a, input logic [2:0] t, input logic [3:0] s,
                         input logic [127:0] d);
      bit got = 0;
      bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_type = t; bus.wr_wstrb = s; bus.wr_data = d;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clock);
         if (bus.wr_rdy) got = 1;
         tick();
      end
      if (!got) chk("wr_req_timeout", 0, 1);
      bus.wr_req = 1'b0;
   endtask

   // Wait for bready (write side must look busy meanwhile), then complete the B handshake.
   task automatic b_resp();
      bit got = 0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clock);
         chk("wr_rdy_busy", bus.wr_rdy, 0);
         chk("d_rd_rdy_busy", bus.d_rd_rdy, 0);
         if (bus.bready) begin
            got = 1;
            bus.bvalid = 1'b1;
         end
         tick();
      end
      if (!got) chk("bready_timeout", 0, 1);
      bus.bvalid = 1'b0;
      @(negedge clock);
      chk("wr_rdy_after_b", bus.wr_rdy, 1);
      chk("bready_after_b", bus.bready, 0);
      tick();
   endtask

   task automatic reset_outputs(input string tag);
      chk({tag, "_valids"}, {bus.arvalid, bus.awvalid, bus.wvalid, bus.bready,
                             bus.i_ret_valid, bus.d_ret_valid}, 6'b0);
      chk({tag, "_rdys"}, {bus.i_rd_rdy, bus.d_rd_rdy, bus.wr_rdy}, 3'b0);
      chk({tag, "_rready"}, bus.rready, 1);
      chk({tag, "_addr"}, {bus.araddr, bus.awaddr}, 64'd0);
      chk({tag, "_data"}, {bus.wdata, bus.ret_data}, 64'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.i_rd_req = 0; bus.i_rd_type = 0; bus.i_rd_addr = 0;
      bus.d_rd_req = 0; bus.d_rd_type = 0; bus.d_rd_addr = 0;
      bus.wr_req = 0; bus.wr_type = 0; bus.wr_addr = 0; bus.wr_wstrb = 0; bus.wr_data = 0;
      bus.arready = 1; bus.awready = 1; bus.wready = 1; bus.bvalid = 0;
      bus.rid = 0; bus.rdata = 0; bus.rlast = 0; bus.rvalid = 0;

      // Reset state
      repeat (3) @(negedge clock);
      reset_outputs("reset");
      tick();
      reset = 1'b0;
      @(negedge clock);
      chk("rdy_after_reset", {bus.i_rd_rdy, bus.d_rd_rdy, bus.wr_rdy}, 3'b111);
      tick();

      // Icache line read
      rd_req(0, 32'h1C00_0000, 3'b100, 8'd3, 3'd2);
      tick();
      @(negedge clock);
      chk("i_rdy_outstanding", bus.i_rd_rdy, 0);
      tick();
      r_send(4'd0, 32'h11, 0);
      r_send(4'd0, 32'h22, 0);
      r_send(4'd0, 32'h33, 0);
      r_send(4'd0, 32'h44, 1);
      @(negedge clock);
      chk("i_rdy_line_done", bus.i_rd_rdy, 1);
      tick();

      // Same-cycle icache and dcache requests: dcache first
      bus.d_rd_req = 1; bus.d_rd_addr = 32'h3000_0000; bus.d_rd_type = 3'b100;
      bus.i_rd_req = 1; bus.i_rd_addr = 32'h1C00_0100; bus.i_rd_type = 3'b100;
      @(negedge clock);
      chk("conflict_d_rdy", bus.d_rd_rdy, 1);
      chk("conflict_i_rdy", bus.i_rd_rdy, 0);
      q_ar.push_back({4'd1, 32'h3000_0000, 8'd3, 3'd2});
      tick();
      bus.d_rd_req = 0;
      @(negedge clock);
      chk("i_rdy_during_send", bus.i_rd_rdy, 0);
      tick();
      rd_req(0, 32'h1C00_0100, 3'b100, 8'd3, 3'd2);
      r_send(4'd1, 32'hA1, 0);
      r_send(4'd0, 32'hB1, 0);
      r_send(4'd1, 32'hA2, 0);
      r_send(4'd0, 32'hB2, 0);
      r_send(4'd1, 32'hA3, 0);
      r_send(4'd1, 32'hA4, 1);
      r_send(4'd0, 32'hB3, 0);
      r_send(4'd0, 32'hB4, 1);
      @(negedge clock);
      chk("rdys_after_interleave", {bus.i_rd_rdy, bus.d_rd_rdy, bus.wr_rdy}, 3'b111);
      tick();

      // Dcache word write
      q_aw.push_back({32'h8000_0010, 8'd0, 3'd2});
      q_w.push_back({32'hDEAD_BEEF, 4'b0011, 1'b1});
      wr_req(32'h8000_0010, 3'b010, 4'b0011, {96'h1234_5678_9ABC_DEF0_0BAD_F00D, 32'hDEAD_BEEF});
      b_resp();
      chk("word_write_drained", q_w.size() + q_aw.size(), 0);

      // Line write with W beats ahead of a delayed awready
      bus.awready = 0;
      q_aw.push_back({32'h8000_0100, 8'd3, 3'd2});
      q_w.push_back({32'h0101_0101, 4'hF, 1'b0});
      q_w.push_back({32'h0202_0202, 4'hF, 1'b0});
      q_w.push_back({32'h0303_0303, 4'hF, 1'b0});
      q_w.push_back({32'h0404_0404, 4'hF, 1'b1});
      wr_req(32'h8000_0100, 3'b100, 4'h1, {32'h0404_0404, 32'h0303_0303, 32'h0202_0202, 32'h0101_0101});
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         chk("line_wr_d_rd_rdy", bus.d_rd_rdy, 0);
         chk("line_wr_awvalid_held", bus.awvalid, 1);
         tick();
      end
      chk("w_before_aw", q_w.size(), 0);
      bus.awready = 1;
      b_resp();
      chk("line_write_aw_drained", q_aw.size(), 0);

      // AR stall: fields held, second dcache request refused
      bus.arready = 0;
      rd_req(1, 32'h3000_0044, 3'b010, 8'd0, 3'd2);
      bus.d_rd_req = 1; bus.d_rd_addr = 32'h3000_0080; bus.d_rd_type = 3'b010;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         chk("ar_stall_valid", bus.arvalid, 1);
         chk("ar_stall_fields", {bus.arid, bus.araddr, bus.arlen}, {4'd1, 32'h3000_0044, 8'd0});
         chk("ar_stall_d_rdy", bus.d_rd_rdy, 0);
         tick();
      end
      bus.d_rd_req = 0;
      bus.arready = 1;
      tick();
      @(negedge clock);
      chk("i_rdy_while_d_out", bus.i_rd_rdy, 1);
      chk("d_rdy_while_d_out", bus.d_rd_rdy, 0);
      chk("wr_rdy_while_d_out", bus.wr_rdy, 0);
      tick();
      r_send(4'd1, 32'hCAFE_0001, 1);
      @(negedge clock);
      chk("d_rdy_after_word", bus.d_rd_rdy, 1);
      tick();

      // Reset in the middle of a line read
      rd_req(0, 32'h1C00_0040, 3'b100, 8'd3, 3'd2);
      tick();
      r_send(4'd0, 32'h55, 0);
      r_send(4'd0, 32'h66, 0);
      bus.rvalid = 1; bus.rid = 4'd0; bus.rdata = 32'h77; bus.rlast = 0;
      reset = 1'b1;
      @(negedge clock);
      reset_outputs("mid_reset");
      tick();
      bus.rvalid = 0;
      reset = 1'b0;
      @(negedge clock);
      chk("rdy_after_mid_reset", {bus.i_rd_rdy, bus.d_rd_rdy, bus.wr_rdy}, 3'b111);
      tick();
      rd_req(0, 32'h1C00_0080, 3'b001, 8'd0, 3'd1);
      tick();
      r_send(4'd0, 32'h0000_BEEF, 1);
      tick();

      chk("queues_empty", q_ar.size() + q_aw.size() + q_w.size() + q_r.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/cache_axi_bridge.md
# cache_axi_bridge

Sits between the two L1 caches (icache, dcache) and the core's AXI master port. It arbitrates cache refill reads and dcache writebacks onto one AXI4 interface and routes read beats back by ID. Supports one outstanding read per cache and one write. Wired in core_top in place of the unconnected `rd_*`, `ret_*` and `wr_*` cache ports.

## Interface
- `LINE_WORDS`, default 4: 32-bit beats per cache line. `arlen`/`awlen` for a line transfer is `LINE_WORDS-1`.
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `i_rd_req` in 1, `i_rd_type` in 3, `i_rd_addr` in 32, `i_rd_rdy` out 1: icache read request.
- `d_rd_req` in 1, `d_rd_type` in 3, `d_rd_addr` in 32, `d_rd_rdy` out 1: dcache read request.
- Type encoding: 3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 line.
- `i_ret_valid` out 1, `d_ret_valid` out 1: per-cache return-beat strobes.
- `ret_last` out 1, `ret_data` out 32: shared return beat.
- `wr_req` in 1, `wr_type` in 3, `wr_addr` in 32, `wr_wstrb` in 4, `wr_data` in 128, `wr_rdy` out 1: dcache write.
- AR channel: `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arvalid` out 1, `arready` in 1.
- R channel: `rid` in 4, `rdata` in 32, `rlast` in 1, `rvalid` in 1, `rready` out 1.
- AW channel: `awaddr` out 32, `awlen` out 8, `awsize` out 3, `awvalid` out 1, `awready` in 1.
- W channel: `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1.
- B channel: `bvalid` in 1, `bready` out 1.
- Tied constant in core_top: `arburst`/`awburst` = INCR, `awid`/`wid` = 1, lock/cache/prot = 0. `rresp`/`bresp` are ignored.

## Operation
- Read-address FSM states:
  - AR_IDLE: capture one request.
  - AR_SEND: `arvalid`=1, fields held stable until `arready`, then return to AR_IDLE.
- Outstanding flags `i_out`/`d_out` are set on capture and cleared on the `rvalid&rlast` beat with the matching `rid`.
- `d_rd_rdy` = AR_IDLE & ~`d_out` & write FSM in W_IDLE.
- `i_rd_rdy` = AR_IDLE & ~`i_out` & W_IDLE & ~(`d_rd_req` & `d_rd_rdy`). The dcache wins a same-cycle conflict.
- Read field mapping:
  - `arid` = 0 for icache, 1 for dcache.
  - Line type: `arlen`=`LINE_WORDS-1`, `arsize`=2.
  - Other types: `arlen`=0, `arsize`={1'b0,type[1:0]}.
- Read return path:
  - `rready` is held at 1.
  - `ret_data`=`rdata` and `ret_last`=`rlast`, combinationally.
  - `i_ret_valid` = `rvalid`&(`rid`==0); `d_ret_valid` = `rvalid`&(`rid`==1).
  - `rid` values other than 0/1 are never issued, so they never occur.
- Write FSM states:
  - W_IDLE: `wr_rdy` = ~`d_out`. Capture on `wr_req&wr_rdy`.
  - W_SEND: `awvalid` until `awready`. Independently, W beats stream from beat counter 0..len with `wlast` on the final beat. Both channels may complete in any order.
  - W_RESP: `bready`=1. On `bvalid`, go to W_IDLE.
- Write field mapping:
  - Line type: `awlen`=`LINE_WORDS-1`, `wstrb`=4'hF, beat k carries `wr_data[32k+31:32k]`.
  - Other types: `awlen`=0, `wstrb`=`wr_wstrb`, data = `wr_data[31:0]`.
- Ordering: no read is accepted while the write FSM is not in W_IDLE. No write is accepted while `d_out`. Icache reads in flight do not block writes.

## Timing
- Reset values: all FSMs idle, `i_out`/`d_out`=0, beat counter 0.
- Outputs during reset: `arvalid`, `awvalid`, `wvalid`, `bready`, all `*_ret_valid`, `*_rdy` = 0. `rready`=1. Address/data outputs = 0.
- Reset mid-transfer abandons it; no completion strobe is generated.
- `*_rdy` depend only on state and `d_rd_req`, never on the requester's own `req`.
- Accept at edge N; `arvalid`/`awvalid`/first `wvalid` high from cycle N+1. The earliest next read accept is the cycle after the `arready` handshake.
- Return beats have zero added latency. `*_ret_valid` may assert while AR_SEND serves the other cache.
- `wr_rdy` rises the cycle after the `bvalid` handshake.
- Payload registers change only at capture.

## Test plan
- Icache line read at 0x1C00_0000:
  - expect `arid`=0, `arlen`=3, `arsize`=2.
  - slave returns 4 beats 0x11..0x44 → `i_ret_valid` ×4, `ret_last` on 0x44 only, `d_ret_valid` stays 0.
- Same-cycle `i_rd_req` and `d_rd_req`:
  - dcache issued first (`arid`=1).
  - icache issued after `arready`.
  - interleaved R beats route correctly by `rid`.
- Dcache word write 0x8000_0010, strb 4'b0011, `wr_data[31:0]`=0xDEAD_BEEF:
  - expect one W beat with `wlast`=1.
  - `wr_rdy` low until the cycle after `bvalid`.
- Line write with W handshakes before `awready` (`awready` delayed 5 cycles):
  - 4 beats in order, then `bready`.
  - `d_rd_rdy`=0 for the whole write.
- Hold `arready`=0 for 10 cycles:
  - `araddr`/`arlen`/`arid` stable.
  - second request from the same cache not accepted (`*_rdy`=0).
- Assert `reset` mid line read after 2 beats:
  - all valids drop immediately.
  - `*_rdy` high the first cycle after reset deasserts.
